// File: rtl/serial_magnitude_compare_ctrl.sv
// serial_magnitude_compare_ctrl
//
// Compares two WIDTH-bit unsigned operands by stepping a single 4-bit magnitude
// slice across the operand nibbles, most significant nibble first. The compare
// stops at the first unequal nibble. This trades latency (1..NIB cycles) for the
// area of a full-width comparator tree.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; aborts any compare in flight
//   start      request a compare; only sampled while idle
//   A, B       operands, captured when start is accepted
//   busy       high while a compare is in progress
//   done       one-cycle pulse when eq/a_less_b/a_gt_b/nib_count are updated
//   eq         A == B for the last completed compare
//   a_less_b   A <  B (unsigned) for the last completed compare
//   a_gt_b     A >  B (unsigned) for the last completed compare
//   nib_count  nibbles examined by the last completed compare (1..NIB)

module serial_magnitude_compare_ctrl #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned NIB = WIDTH / 4,
  localparam int unsigned CW  = $clog2(NIB) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             a_less_b,
  output logic             a_gt_b,
  output logic [CW-1:0]    nib_count
);

  // Index width; kept at least 1 bit so a single-nibble build still elaborates.
  localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StCompare
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic [CW-1:0]    nib_count_q, nib_count_d;

  // Shared 4-bit slice: select the current nibble of each captured operand.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       a_nib, b_nib;
  logic             slice_eq, slice_lt, slice_gt;

  always_comb begin
    a_sh     = a_q >> {idx_q, 2'b00};
    b_sh     = b_q >> {idx_q, 2'b00};
    a_nib    = a_sh[3:0];
    b_nib    = b_sh[3:0];
    slice_eq = (a_nib == b_nib);
    slice_lt = (a_nib < b_nib);
    slice_gt = (a_nib > b_nib);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    eq_d        = eq_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    nib_count_d = nib_count_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IW'(NIB - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCompare;
        end
      end

      StCompare: begin
        cnt_d = cnt_q + CW'(1);
        if (!slice_eq) begin
          // First differing nibble decides the whole compare.
          eq_d        = 1'b0;
          lt_d        = slice_lt;
          gt_d        = slice_gt;
          nib_count_d = cnt_q + CW'(1);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else if (idx_q == '0) begin
          eq_d        = 1'b1;
          lt_d        = 1'b0;
          gt_d        = 1'b0;
          nib_count_d = CW'(NIB);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      nib_count_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      nib_count_q <= nib_count_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign eq        = eq_q;
  assign a_less_b  = lt_q;
  assign a_gt_b    = gt_q;
  assign nib_count = nib_count_q;

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Self-checking bench for serial_magnitude_compare_ctrl (WIDTH = 16).
// Expected results are queued when a compare is launched and checked by a
// monitor when done pulses; latency and busy length are checked per compare.

module tb_serial_magnitude_compare_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;
  localparam int unsigned CW  = $clog2(NIB) + 1;

  typedef struct {
    logic          eq;
    logic          lt;
    logic          gt;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic          eq;
  logic          a_less_b;
  logic          a_gt_b;
  logic [CW-1:0] nib_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  serial_magnitude_compare_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .a_less_b (a_less_b),
    .a_gt_b   (a_gt_b),
    .nib_count(nib_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.eq  = (a == b);
    e.lt  = (a < b);
    e.gt  = (a > b);
    e.cnt = CW'(NIB);
    for (int i = NIB - 1; i >= 0; i--) begin
      if (a[4*i +: 4] != b[4*i +: 4]) begin
        e.cnt = CW'(NIB - i);
        break;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_and_done actual=1 required=0");
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("eq", 32'(eq), 32'(e.eq));
        chk("a_less_b", 32'(a_less_b), 32'(e.lt));
        chk("a_gt_b", 32'(a_gt_b), 32'(e.gt));
        chk("nib_count", 32'(nib_count), 32'(e.cnt));
      end
    end
  end

  // Waits (bounded) for done; returns the cycle stamp at which it was seen.
  task automatic wait_done(input string name, output int at, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = busy ? 1 : 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_cycles++;
    end while (!done && n < NIB + 4);
    at = cyc;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                        input string name);
    int t0, t1, bc;
    @(posedge clk);
    #1;
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    wait_done(name, t1, bc);
    chk({name, "_latency"}, 32'(t1 - t0), 32'(e.cnt));
    chk({name, "_busy_len"}, 32'(bc), 32'(e.cnt));
  endtask

  vec_t vecs[6];

  initial begin
    int t0, t1, t2, t3, bc;
    exp_t e;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 16'hF000, b: 16'h0FFF, e: '{eq: 0, lt: 0, gt: 1, cnt: 3'd1}};
    vecs[1] = '{a: 16'hA5A5, b: 16'hA5A5, e: '{eq: 1, lt: 0, gt: 0, cnt: 3'd4}};
    vecs[2] = '{a: 16'h1230, b: 16'h1231, e: '{eq: 0, lt: 1, gt: 0, cnt: 3'd4}};
    vecs[3] = '{a: 16'h1C00, b: 16'h1B00, e: '{eq: 0, lt: 0, gt: 1, cnt: 3'd2}};
    vecs[4] = '{a: 16'h0000, b: 16'hFFFF, e: '{eq: 0, lt: 1, gt: 0, cnt: 3'd1}};
    vecs[5] = '{a: 16'h98F7, b: 16'h98A7, e: '{eq: 0, lt: 0, gt: 1, cnt: 3'd3}};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_eq", 32'(eq), 0);
    chk("rst_lt", 32'(a_less_b), 0);
    chk("rst_gt", 32'(a_gt_b), 0);
    chk("rst_cnt", 32'(nib_count), 0);
    rst = 1'b0;

    // Abort mid-compare: no done may appear and outputs stay cleared.
    @(posedge clk);
    #1;
    A = 16'h1234;
    B = 16'h1235;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_eq", 32'(eq), 0);
    chk("abort_lt", 32'(a_less_b), 0);
    chk("abort_gt", 32'(a_gt_b), 0);
    chk("abort_cnt", 32'(nib_count), 0);
    repeat (8) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      do_cmp(vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_model", i), 32'(model(vecs[i].a, vecs[i].b).cnt),
          32'(vecs[i].e.cnt));
    end

    // Start pulsed while busy must be ignored.
    @(posedge clk);
    #1;
    A = 16'h0001;
    B = 16'h0002;
    start = 1'b1;
    sb.push_back('{eq: 0, lt: 1, gt: 0, cnt: 3'd4});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    A = 16'hFFFF;
    B = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", t1, bc);
    chk("ignore_lt", 32'(a_less_b), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("ignore_sb_empty", 32'(sb.size()), 0);

    // Back-to-back with start held high: m+1 cycles between done pulses.
    @(posedge clk);
    #1;
    t0 = cyc;
    A = 16'h8000;
    B = 16'h8000;
    start = 1'b1;
    sb.push_back('{eq: 1, lt: 0, gt: 0, cnt: 3'd4});
    wait_done("b2b0", t1, bc);
    chk("b2b_first", 32'(t1 - t0), 5);
    sb.push_back('{eq: 1, lt: 0, gt: 0, cnt: 3'd4});
    wait_done("b2b1", t2, bc);
    chk("b2b_gap_eq", 32'(t2 - t1), 5);
    A = 16'h7FFF;
    sb.push_back('{eq: 0, lt: 1, gt: 0, cnt: 3'd1});
    wait_done("b2b2", t3, bc);
    chk("b2b_gap_lt", 32'(t3 - t2), 2);
    start = 1'b0;
    repeat (4) @(posedge clk);

    // Random pairs, biased so leading nibbles often match.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = ra;
      if ($urandom_range(0, 7) != 0) begin
        rb[4*$urandom_range(0, NIB - 1) +: 4] = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        rb = W'($urandom);
      end
      e = model(ra, rb);
      do_cmp(ra, rb, e, "rand");
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_compare_ctrl.md
Name: serial_magnitude_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands by stepping one shared 4-bit magnitude-compare slice across the operand nibbles, MSB nibble first.
- Stops at the first unequal nibble.
- Trades latency for area against a fully parallel comparator tree.
- Used wherever wide compares are infrequent, e.g. threshold checks behind a register interface.
- start/done handshake.
- Reports eq / a_less_b / a_gt_b and the number of nibbles examined.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived: number of nibbles (localparam).
- CW, $clog2(NIB)+1, derived: width of nib_count (localparam).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request compare; sampled only in IDLE
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse: results valid/updated
- eq  output  1  A == B (last completed compare)
- a_less_b  output  1  A < B unsigned (last completed compare)
- a_gt_b  output  1  A > B unsigned (last completed compare)
- nib_count  output  CW  nibbles examined in last compare (1..NIB)

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, done, eq, a_less_b and a_gt_b all go to 0; nib_count goes to 0.
  - Operand and index registers are cleared.
  - rst has priority over start and over any in-flight compare; an aborted compare produces no done.
- States: IDLE, COMPARE. All outputs are registered.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch A into a_r and B into b_r; set idx=NIB-1; clear the internal examined-count; busy=1; go to COMPARE.
  - If start=0: stay in IDLE.
- COMPARE, one nibble per cycle:
  - The slice compares a_r[4*idx+3:4*idx] against b_r[4*idx+3:4*idx]; the count increments.
  - Nibble unequal: at the edge, load eq=0, a_less_b=lt and a_gt_b=gt from the slice, set nib_count=count+1, pulse done=1, set busy=0, go to IDLE.
  - Nibble equal and idx==0: load eq=1, a_less_b=0, a_gt_b=0, set nib_count=NIB, pulse done=1, set busy=0, go to IDLE.
  - Nibble equal and idx>0: idx decrements, stay in COMPARE.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+m, where m = number of nibbles examined (1..NIB).
  - Best case is 1 cycle (MSB nibble differs).
  - Worst case is NIB cycles (operands equal, or only nibble 0 differs).
- Output invariants:
  - eq, a_less_b and a_gt_b are one-hot after the first completion, and all 0 before it.
  - They change only at an edge where done is set; otherwise they hold.
  - They are not cleared on start.
- done is high for exactly one cycle per compare. busy and done are never high together.
- Handshake:
  - start while busy=1 is ignored: no queuing, and A/B changes do not affect the compare in flight.
  - start high during the done cycle (state already IDLE) is accepted, giving back-to-back compares with no bubble.
  - start held high continuously produces a compare every m+1 cycles.
- Operands are captured, so A and B may change the cycle after an accepted start.
- The 4-bit slice is purely combinational: eq = (x==y), lt = (x<y), gt = (x>y).

Test Plan:
- Reset: assert rst for 2 cycles mid-compare (A=16'h1234, B=16'h1235, after 2 compare cycles) -> busy=0, done never pulses, eq/a_less_b/a_gt_b/nib_count=0.
- MSB early exit: A=16'hF000, B=16'h0FFF, start -> done 1 cycle after acceptance, a_gt_b=1, eq=0, a_less_b=0, nib_count=1.
- Full scan, equal: A=B=16'hA5A5 -> done 4 cycles after acceptance, eq=1, others 0, nib_count=4.
- LSB difference: A=16'h1230, B=16'h1231 -> done after 4 cycles, a_less_b=1, nib_count=4; busy high for exactly 4 cycles.
- Start ignored while busy: A=16'h0001, B=16'h0002, start; pulse start again with A=16'hFFFF, B=16'h0000 during cycle 2 -> single done, a_less_b=1; no second compare.
- Back-to-back plus random: start held high with A=16'h8000/B=16'h8000, then A=16'h7FFF/B=16'h8000 -> done pulses separated by 5 and 2 cycles as derived from m.
  - Follow with 1000 random operand pairs (plus WIDTH=4 and WIDTH=32 builds) checked against a reference unsigned compare and the nibble-count model.
